// File: rtl/sdram_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : sdram_port_arbiter
// Purpose  : Two-client arbiter in front of the sdram_core application port,
//            with latched bursts, owner-only strobe routing and a watchdog.
// Revision : 1.0
// ============================================================================
module sdram_port_arbiter #(
    parameter int ADDR_W      = 24,
    parameter int LEN_W       = 10,
    parameter int DATA_W      = 16,
    parameter int C1_PRIORITY = 0,
    parameter int TIMEOUT     = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_c0_rd_req,
    input  logic              i_c0_wr_req,
    input  logic [ADDR_W-1:0] i_c0_rd_addr,
    input  logic [ADDR_W-1:0] i_c0_wr_addr,
    input  logic [LEN_W-1:0]  i_c0_rd_len,
    input  logic [LEN_W-1:0]  i_c0_wr_len,
    input  logic [DATA_W-1:0] i_c0_wr_data,
    output logic              o_c0_wr_data_req,
    output logic              o_c0_wr_finish,
    output logic              o_c0_rd_data_valid,
    output logic              o_c0_rd_finish,
    input  logic              i_c1_rd_req,
    input  logic [ADDR_W-1:0] i_c1_rd_addr,
    input  logic [LEN_W-1:0]  i_c1_rd_len,
    output logic              o_c1_rd_data_valid,
    output logic              o_c1_rd_finish,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_m_rd_req,
    output logic              o_m_wr_req,
    output logic [ADDR_W-1:0] o_m_rd_addr,
    output logic [ADDR_W-1:0] o_m_wr_addr,
    output logic [LEN_W-1:0]  o_m_rd_len,
    output logic [LEN_W-1:0]  o_m_wr_len,
    output logic [DATA_W-1:0] o_m_wr_data,
    input  logic              i_m_wr_data_req,
    input  logic              i_m_wr_finish,
    input  logic [DATA_W-1:0] i_m_rd_data,
    input  logic              i_m_rd_data_valid,
    input  logic              i_m_rd_finish,
    output logic              o_timeout_err,
    output logic              o_busy
);

    localparam int                c_WD_W    = $clog2(TIMEOUT);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);
    localparam logic [1:0]        c_OWN_C0R = 2'd0;
    localparam logic [1:0]        c_OWN_C0W = 2'd1;
    localparam logic [1:0]        c_OWN_C1R = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_G0R  = 3'd1,
        S_G0W  = 3'd2,
        S_G1R  = 3'd3,
        S_REL  = 3'd4
    } state_t;

    state_t              r_state;
    logic [1:0]          r_owner;
    logic                r_rr_c1;
    logic [c_WD_W-1:0]   r_wd;
    logic                r_m_rd_req;
    logic                r_m_wr_req;
    logic [ADDR_W-1:0]   r_m_rd_addr;
    logic [ADDR_W-1:0]   r_m_wr_addr;
    logic [LEN_W-1:0]    r_m_rd_len;
    logic [LEN_W-1:0]    r_m_wr_len;

    logic w_in_g;
    logic w_fin;
    logic w_timeout;
    logic w_end;
    logic w_c0_any;
    logic w_pick_c1;
    logic w_owner_req;

    assign w_in_g    = (r_state == S_G0R) || (r_state == S_G0W) || (r_state == S_G1R);
    // Only the finish of the granted direction ends a burst.
    assign w_fin     = (((r_state == S_G0R) || (r_state == S_G1R)) && i_m_rd_finish)
                     || ((r_state == S_G0W) && i_m_wr_finish);
    assign w_timeout = w_in_g && !w_fin && (r_wd == c_WD_LAST);
    assign w_end     = w_fin || w_timeout;
    assign w_c0_any  = i_c0_rd_req || i_c0_wr_req;
    assign w_pick_c1 = i_c1_rd_req && (!w_c0_any || (C1_PRIORITY != 0) || r_rr_c1);
    assign w_owner_req = (r_owner == c_OWN_C0R) ? i_c0_rd_req :
                         (r_owner == c_OWN_C0W) ? i_c0_wr_req : i_c1_rd_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_owner     <= c_OWN_C0R;
            r_rr_c1     <= 1'b1;
            r_wd        <= '0;
            r_m_rd_req  <= 1'b0;
            r_m_wr_req  <= 1'b0;
            r_m_rd_addr <= '0;
            r_m_wr_addr <= '0;
            r_m_rd_len  <= '0;
            r_m_wr_len  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wd <= '0;
                    if (w_pick_c1) begin
                        r_state     <= S_G1R;
                        r_owner     <= c_OWN_C1R;
                        r_rr_c1     <= 1'b0;
                        r_m_rd_req  <= 1'b1;
                        r_m_rd_addr <= i_c1_rd_addr;
                        r_m_rd_len  <= i_c1_rd_len;
                    end else if (i_c0_wr_req) begin
                        r_state     <= S_G0W;
                        r_owner     <= c_OWN_C0W;
                        r_rr_c1     <= 1'b1;
                        r_m_wr_req  <= 1'b1;
                        r_m_wr_addr <= i_c0_wr_addr;
                        r_m_wr_len  <= i_c0_wr_len;
                    end else if (i_c0_rd_req) begin
                        r_state     <= S_G0R;
                        r_owner     <= c_OWN_C0R;
                        r_rr_c1     <= 1'b1;
                        r_m_rd_req  <= 1'b1;
                        r_m_rd_addr <= i_c0_rd_addr;
                        r_m_rd_len  <= i_c0_rd_len;
                    end
                end
                S_G0R, S_G0W, S_G1R: begin
                    if (w_end) begin
                        r_state    <= S_REL;
                        r_m_rd_req <= 1'b0;
                        r_m_wr_req <= 1'b0;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                // Hold off until the owner drops its level request, so it is not re-served.
                S_REL: begin
                    if (!w_owner_req) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_m_rd_req         = r_m_rd_req;
    assign o_m_wr_req         = r_m_wr_req;
    assign o_m_rd_addr        = r_m_rd_addr;
    assign o_m_wr_addr        = r_m_wr_addr;
    assign o_m_rd_len         = r_m_rd_len;
    assign o_m_wr_len         = r_m_wr_len;
    assign o_m_wr_data        = i_c0_wr_data;
    assign o_rd_data          = i_m_rd_data;
    assign o_c0_wr_data_req   = (r_state == S_G0W) && i_m_wr_data_req;
    assign o_c0_rd_data_valid = (r_state == S_G0R) && i_m_rd_data_valid;
    assign o_c1_rd_data_valid = (r_state == S_G1R) && i_m_rd_data_valid;
    assign o_c0_wr_finish     = (r_state == S_G0W) && w_end;
    assign o_c0_rd_finish     = (r_state == S_G0R) && w_end;
    assign o_c1_rd_finish     = (r_state == S_G1R) && w_end;
    assign o_timeout_err      = w_timeout;
    assign o_busy             = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sdram_port_arbiter
// Purpose  : Directed scenarios plus random traffic against a burst-level model.
// Revision : 1.0
// ============================================================================
module tb_sdram_port_arbiter;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c0_rd_req, c0_wr_req, c1_rd_req;
    logic [23:0] c0_rd_addr, c0_wr_addr, c1_rd_addr;
    logic [9:0]  c0_rd_len, c0_wr_len, c1_rd_len;
    logic [15:0] c0_wr_data, m_rd_data;
    logic        m_wr_data_req, m_wr_finish, m_rd_data_valid, m_rd_finish;
    logic        c0_wr_data_req, c0_wr_finish, c0_rd_data_valid, c0_rd_finish;
    logic        c1_rd_data_valid, c1_rd_finish;
    logic [15:0] rd_data, m_wr_data;
    logic        m_rd_req, m_wr_req, timeout_err, busy;
    logic [23:0] m_rd_addr, m_wr_addr;
    logic [9:0]  m_rd_len, m_wr_len;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .ADDR_W(24), .LEN_W(10), .DATA_W(16), .C1_PRIORITY(0), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_c0_rd_req(c0_rd_req), .i_c0_wr_req(c0_wr_req),
        .i_c0_rd_addr(c0_rd_addr), .i_c0_wr_addr(c0_wr_addr),
        .i_c0_rd_len(c0_rd_len), .i_c0_wr_len(c0_wr_len),
        .i_c0_wr_data(c0_wr_data),
        .o_c0_wr_data_req(c0_wr_data_req), .o_c0_wr_finish(c0_wr_finish),
        .o_c0_rd_data_valid(c0_rd_data_valid), .o_c0_rd_finish(c0_rd_finish),
        .i_c1_rd_req(c1_rd_req), .i_c1_rd_addr(c1_rd_addr), .i_c1_rd_len(c1_rd_len),
        .o_c1_rd_data_valid(c1_rd_data_valid), .o_c1_rd_finish(c1_rd_finish),
        .o_rd_data(rd_data),
        .o_m_rd_req(m_rd_req), .o_m_wr_req(m_wr_req),
        .o_m_rd_addr(m_rd_addr), .o_m_wr_addr(m_wr_addr),
        .o_m_rd_len(m_rd_len), .o_m_wr_len(m_wr_len),
        .o_m_wr_data(m_wr_data),
        .i_m_wr_data_req(m_wr_data_req), .i_m_wr_finish(m_wr_finish),
        .i_m_rd_data(m_rd_data), .i_m_rd_data_valid(m_rd_data_valid),
        .i_m_rd_finish(m_rd_finish),
        .o_timeout_err(timeout_err), .o_busy(busy)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Burst-level model: mode 0 = nobody served, 1 = burst open, 2 = waiting for owner to let go.
    // Burst kind: 0 = client 0 read, 1 = client 0 write, 2 = client 1 read.
    int          md_mode, md_who, md_age, md_last;
    logic [23:0] md_raddr, md_waddr;
    logic [9:0]  md_rlen, md_wlen;

    function automatic bit f_fin();
        return (md_mode == 1) && ((md_who == 1) ? m_wr_finish : m_rd_finish);
    endfunction

    function automatic bit f_to();
        return (md_mode == 1) && !f_fin() && (md_age == TIMEOUT - 1);
    endfunction

    function automatic bit f_owner_req();
        case (md_who)
            0:       return c0_rd_req;
            1:       return c0_wr_req;
            default: return c1_rd_req;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_mode <= 0; md_who <= 0; md_age <= 0; md_last <= 0;
            md_raddr <= '0; md_rlen <= '0; md_waddr <= '0; md_wlen <= '0;
        end else if (md_mode == 0) begin
            if (c1_rd_req && (!(c0_rd_req || c0_wr_req) || md_last == 0)) begin
                md_mode <= 1; md_who <= 2; md_age <= 0; md_last <= 1;
                md_raddr <= c1_rd_addr; md_rlen <= c1_rd_len;
            end else if (c0_rd_req || c0_wr_req) begin
                md_mode <= 1; md_who <= c0_wr_req ? 1 : 0; md_age <= 0; md_last <= 0;
                if (c0_wr_req) begin
                    md_waddr <= c0_wr_addr; md_wlen <= c0_wr_len;
                end else begin
                    md_raddr <= c0_rd_addr; md_rlen <= c0_rd_len;
                end
            end
        end else if (md_mode == 1) begin
            if (f_fin() || f_to()) md_mode <= 2;
            else                   md_age  <= md_age + 1;
        end else if (!f_owner_req()) begin
            md_mode <= 0;
        end
    end

    always @(negedge clk) begin
        check("mdl_ctl", {m_rd_req, m_wr_req, busy, timeout_err},
              {md_mode == 1 && md_who != 1, md_mode == 1 && md_who == 1, md_mode != 0, f_to()});
        check("mdl_client",
              {c0_wr_data_req, c0_wr_finish, c0_rd_data_valid, c0_rd_finish, c1_rd_data_valid, c1_rd_finish},
              {md_mode == 1 && md_who == 1 && m_wr_data_req,
               md_who == 1 && (f_fin() || f_to()),
               md_mode == 1 && md_who == 0 && m_rd_data_valid,
               md_who == 0 && (f_fin() || f_to()),
               md_mode == 1 && md_who == 2 && m_rd_data_valid,
               md_who == 2 && (f_fin() || f_to())});
        check("mdl_latch", {m_rd_addr, m_rd_len, m_wr_addr, m_wr_len},
              {md_raddr, md_rlen, md_waddr, md_wlen});
        check("mdl_data", {rd_data, m_wr_data}, {m_rd_data, c0_wr_data});
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_grant(input bit wr, input string name);
        int n = 0;
        while (!(wr ? m_wr_req : m_rd_req) && n < 30) begin
            step();
            n++;
        end
        check(name, wr ? m_wr_req : m_rd_req, 1'b1);
    endtask

    task automatic rand_cycle(input int fin_div);
        if (!c0_rd_req) begin
            if ($urandom_range(0, 3) == 0) begin
                c0_rd_req = 1'b1; c0_rd_addr = 24'($urandom); c0_rd_len = 10'($urandom);
            end
        end else if ($urandom_range(0, 7) == 0) c0_rd_req = 1'b0;
        else if ($urandom_range(0, 7) == 0) c0_rd_addr = 24'($urandom);
        if (!c0_wr_req) begin
            if ($urandom_range(0, 5) == 0) begin
                c0_wr_req = 1'b1; c0_wr_addr = 24'($urandom); c0_wr_len = 10'($urandom);
            end
        end else if ($urandom_range(0, 7) == 0) c0_wr_req = 1'b0;
        else if ($urandom_range(0, 7) == 0) c0_wr_len = 10'($urandom);
        if (!c1_rd_req) begin
            if ($urandom_range(0, 3) == 0) begin
                c1_rd_req = 1'b1; c1_rd_addr = 24'($urandom); c1_rd_len = 10'($urandom);
            end
        end else if ($urandom_range(0, 7) == 0) c1_rd_req = 1'b0;
        else if ($urandom_range(0, 7) == 0) c1_rd_addr = 24'($urandom);
        c0_wr_data      = 16'($urandom);
        m_rd_data       = 16'($urandom);
        m_rd_data_valid = ($urandom_range(0, 2) == 0);
        m_wr_data_req   = ($urandom_range(0, 2) == 0);
        m_rd_finish     = ($urandom_range(0, fin_div - 1) == 0);
        m_wr_finish     = ($urandom_range(0, fin_div - 1) == 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1, "bench stuck");
    end

    initial begin
        logic who;
        int   hi, to_n, fin_n;
        rst_n = 1'b0;
        {c0_rd_req, c0_wr_req, c1_rd_req} = 3'b000;
        c0_rd_addr = '0; c0_wr_addr = '0; c1_rd_addr = '0;
        c0_rd_len = '0; c0_wr_len = '0; c1_rd_len = '0;
        c0_wr_data = '0; m_rd_data = '0;
        {m_wr_data_req, m_wr_finish, m_rd_data_valid, m_rd_finish} = 4'b0000;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("reset_ctl", {m_rd_req, m_wr_req, busy, timeout_err, c0_wr_data_req, c0_wr_finish,
                            c0_rd_data_valid, c0_rd_finish, c1_rd_data_valid, c1_rd_finish}, '0);
        check("reset_latch", {m_rd_addr, m_rd_len, m_wr_addr, m_wr_len, rd_data}, '0);

        // Single client-0 write burst.
        step();
        c0_wr_addr = 24'h900010; c0_wr_len = 10'd1; c0_wr_data = 16'hA301; c0_wr_req = 1'b1;
        #1 check("wr_not_yet", m_wr_req, 1'b0);
        step();
        #1 check("wr_grant", {m_wr_req, m_wr_addr, m_wr_len, busy}, {1'b1, 24'h900010, 10'd1, 1'b1});
        check("wr_data", m_wr_data, 16'hA301);
        m_wr_data_req = 1'b1;
        #1 check("wr_dreq", c0_wr_data_req, 1'b1);
        step(); m_wr_data_req = 1'b0;
        repeat (4) step();
        m_wr_finish = 1'b1;
        #1 check("wr_finish", {c0_wr_finish, timeout_err}, 2'b10);
        step(); m_wr_finish = 1'b0; c0_wr_req = 1'b0;
        #1 check("wr_release", {m_wr_req, c0_wr_finish, busy}, 3'b001);
        step();
        #1 check("wr_idle", busy, 1'b0);

        // Contention from reset: round-robin must start with client 1 and alternate.
        rst_n = 1'b0; step(); step(); rst_n = 1'b1;
        c0_rd_addr = 24'h000100; c0_rd_len = 10'd4;
        c1_rd_addr = 24'h900000; c1_rd_len = 10'd8;
        c0_rd_req = 1'b1; c1_rd_req = 1'b1;
        for (int r = 0; r < 4; r++) begin
            wait_grant(1'b0, "rr_grant_wait");
            who = (m_rd_addr == 24'h900000);
            check("rr_order", who, (r % 2) == 0);
            m_rd_data_valid = 1'b1; m_rd_data = 16'h5A00 + 16'(r);
            #1 check("rr_valid_route", {c0_rd_data_valid, c1_rd_data_valid, rd_data},
                     {!who, who, 16'h5A00 + 16'(r)});
            step(); m_rd_data_valid = 1'b0; m_rd_finish = 1'b1;
            #1 check("rr_finish_route", {c0_rd_finish, c1_rd_finish}, {!who, who});
            if (who) c1_rd_req = 1'b0; else c0_rd_req = 1'b0;
            step(); m_rd_finish = 1'b0;
            step();
            if (who) c1_rd_req = 1'b1; else c0_rd_req = 1'b1;
        end
        c0_rd_req = 1'b0; c1_rd_req = 1'b0;
        repeat (3) step();

        // Client 1 keeps requesting after its finish: exactly one burst.
        c1_rd_req = 1'b1; c1_rd_addr = 24'h900020; c1_rd_len = 10'd3;
        wait_grant(1'b0, "hold_grant_wait");
        m_rd_finish = 1'b1;
        step(); m_rd_finish = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("hold_no_regrant", {m_rd_req, busy}, 2'b01);
            if (i < 2) step();
        end
        c1_rd_req = 1'b0;
        step();
        #1 check("hold_idle", {m_rd_req, busy}, 2'b00);
        step();
        #1 check("hold_still_idle", {m_rd_req, busy}, 2'b00);

        // Watchdog: core never finishes a client-0 read; client 1 waits meanwhile.
        c0_rd_req = 1'b1; c0_rd_addr = 24'h000200; c0_rd_len = 10'd3;
        wait_grant(1'b0, "to_grant_wait");
        c1_rd_req = 1'b1; c1_rd_addr = 24'h900040; c1_rd_len = 10'd2;
        hi = 0; to_n = 0; fin_n = 0;
        for (int i = 0; i < 40 && to_n == 0; i++) begin
            #1;
            if (m_rd_req)     hi++;
            if (timeout_err)  to_n++;
            if (c0_rd_finish) fin_n++;
            if (to_n == 0) step();
        end
        check("to_req_cycles", hi, 16);
        check("to_pulses", {to_n[7:0], fin_n[7:0]}, {8'd1, 8'd1});
        c0_rd_req = 1'b0;
        step();
        #1 check("to_release", {m_rd_req, timeout_err, c0_rd_finish, c1_rd_finish}, 4'b0000);
        step(); step();
        #1 check("to_next_served", {m_rd_req, m_rd_addr, m_rd_len}, {1'b1, 24'h900040, 10'd2});
        m_rd_finish = 1'b1;
        step(); m_rd_finish = 1'b0; c1_rd_req = 1'b0;
        step(); step();

        // Asynchronous reset in the middle of a write burst.
        c0_wr_req = 1'b1; c0_wr_addr = 24'h123456; c0_wr_len = 10'd7;
        wait_grant(1'b1, "ar_grant_wait");
        step(); step();
        m_wr_data_req = 1'b1;
        #1 rst_n = 1'b0;
        #1 check("ar_outputs", {m_rd_req, m_wr_req, busy, timeout_err, c0_wr_data_req, c0_wr_finish,
                                c0_rd_data_valid, c0_rd_finish, c1_rd_data_valid, c1_rd_finish}, '0);
        check("ar_latch", {m_wr_addr, m_wr_len}, '0);
        m_wr_data_req = 1'b0;
        step();
        #1 check("ar_held", {m_wr_req, busy}, 2'b00);
        rst_n = 1'b1;
        step();
        #1 check("ar_regrant", {m_wr_req, m_wr_addr, m_wr_len}, {1'b1, 24'h123456, 10'd7});
        m_wr_finish = 1'b1;
        step(); m_wr_finish = 1'b0; c0_wr_req = 1'b0;
        step(); step();

        // Random traffic: normal finishes, then mostly hung core to provoke the watchdog.
        for (int i = 0; i < 1500; i++) begin
            rand_cycle(6);
            step();
        end
        for (int i = 0; i < 1500; i++) begin
            rand_cycle(40);
            step();
        end
        {c0_rd_req, c0_wr_req, c1_rd_req} = 3'b000;
        {m_wr_data_req, m_wr_finish, m_rd_data_valid, m_rd_finish} = 4'b0000;
        repeat (40) step();
        check("final_idle", {m_rd_req, m_wr_req, busy}, 3'b000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
